// File: rtl/cu_seq_if.sv
// Handshake bundle between the IR/flag/control-word sources and the microsequencer.
// instr_count exists only when CU_INSTR_COUNT_EN is defined.
interface cu_seq_if #(
  parameter int CAR_W = 7,
  parameter int OPC_W = 8
);
  logic             start;
  logic [1:0]       car_ctrl;
  logic             cw_halt;
  logic [OPC_W-1:0] opcode;
  logic             ind_bit;
  logic             acc_gt_zero;
  logic             mf;
  logic             mem_wait;
  logic [CAR_W-1:0] car;
  logic             cw_valid;
  logic             running;
  logic             halted;
  logic             instr_done;
  logic             illegal_op;
`ifdef CU_INSTR_COUNT_EN
  logic [31:0]      instr_count;

  modport master (
    output start, car_ctrl, cw_halt, opcode, ind_bit, acc_gt_zero, mf, mem_wait,
    input  car, cw_valid, running, halted, instr_done, illegal_op, instr_count
  );
  modport slave (
    input  start, car_ctrl, cw_halt, opcode, ind_bit, acc_gt_zero, mf, mem_wait,
    output car, cw_valid, running, halted, instr_done, illegal_op, instr_count
  );
`else
  modport master (
    output start, car_ctrl, cw_halt, opcode, ind_bit, acc_gt_zero, mf, mem_wait,
    input  car, cw_valid, running, halted, instr_done, illegal_op
  );
  modport slave (
    input  start, car_ctrl, cw_halt, opcode, ind_bit, acc_gt_zero, mf, mem_wait,
    output car, cw_valid, running, halted, instr_done, illegal_op
  );
`endif
endinterface

// File: rtl/cu_microsequencer.sv
// Next-address sequencer owning the control address register of the microprogrammed CU.
// Optional retired-instruction counter enabled by defining CU_INSTR_COUNT_EN.
module cu_microsequencer #(
  parameter int               CAR_W       = 7,
  parameter int               OPC_W       = 8,
  parameter logic [CAR_W-1:0] FETCH_ADDR  = 7'h00,
  parameter logic [CAR_W-1:0] FO_ADDR     = 7'h04,
  parameter logic [CAR_W-1:0] IND_ADDR    = 7'h05,
  parameter logic [CAR_W-1:0] NOP_ADDR    = 7'h1F,
  parameter logic [CAR_W-1:0] STOREH_ADDR = 7'h21
) (
  input logic   clk,
  input logic   rst_n,
  cu_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [CAR_W-1:0] STORE_WB_ADDR = CAR_W'(7'h08);

  logic [1:0]       state_q, state_d;
  logic [CAR_W-1:0] car_q, car_d;
  logic             done_q, done_d;
  logic             ill_q, ill_d;
  logic [CAR_W:0]   map_s;
  logic             cw_valid_s;

  // Returns {illegal, target} for the opcode dispatch table.
  function automatic logic [CAR_W:0] map_opcode(input logic [OPC_W-1:0] op, input logic gt);
    logic [CAR_W:0] r;
    case (op)
      OPC_W'(8'h01): r = {1'b0, CAR_W'(7'h07)};
      OPC_W'(8'h02): r = {1'b0, CAR_W'(7'h09)};
      OPC_W'(8'h03): r = {1'b0, CAR_W'(7'h0B)};
      OPC_W'(8'h04): r = {1'b0, CAR_W'(7'h0D)};
      OPC_W'(8'h05): r = {1'b0, (gt ? CAR_W'(7'h11) : NOP_ADDR)};
      OPC_W'(8'h06): r = {1'b0, CAR_W'(7'h11)};
      OPC_W'(8'h07): r = {1'b0, CAR_W'(7'h13)};
      OPC_W'(8'h08): r = {1'b0, CAR_W'(7'h0F)};
      OPC_W'(8'h0A): r = {1'b0, CAR_W'(7'h15)};
      OPC_W'(8'h0B): r = {1'b0, CAR_W'(7'h17)};
      OPC_W'(8'h0C): r = {1'b0, CAR_W'(7'h19)};
      OPC_W'(8'h0D): r = {1'b0, CAR_W'(7'h1B)};
      OPC_W'(8'h0E): r = {1'b0, CAR_W'(7'h1D)};
      default:       r = {1'b1, NOP_ADDR};
    endcase
    return r;
  endfunction

  assign map_s      = map_opcode(bus.opcode, bus.acc_gt_zero);
  assign cw_valid_s = (state_q == ST_RUN) && !bus.mem_wait;

  // Next-state, next-CAR and retire/illegal pulse decode; halt outranks car_ctrl.
  always_comb begin
    state_d = state_q;
    car_d   = car_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (!cw_valid_s) begin
          car_d = car_q;
        end else if (bus.cw_halt) begin
          state_d = ST_HALTED;
          car_d   = FETCH_ADDR;
          done_d  = 1'b1;
        end else begin
          case (bus.car_ctrl)
            2'b00: car_d = car_q;
            2'b10: car_d = car_q + CAR_W'(1);
            2'b11: begin
              if ((car_q == STORE_WB_ADDR) && bus.mf) begin
                car_d = STOREH_ADDR;
              end else begin
                car_d  = FETCH_ADDR;
                done_d = 1'b1;
              end
            end
            2'b01: begin
              if ((car_q == FO_ADDR) && bus.ind_bit) begin
                car_d = IND_ADDR;
              end else begin
                car_d = map_s[CAR_W-1:0];
                ill_d = map_s[CAR_W];
              end
            end
            default: car_d = car_q;
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
        car_d   = FETCH_ADDR;
      end
    endcase
  end

  // Sequencer state, CAR and single-cycle pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      car_q   <= FETCH_ADDR;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      car_q   <= car_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.car        = car_q;
  assign bus.cw_valid   = cw_valid_s;
  assign bus.running    = (state_q == ST_RUN);
  assign bus.halted     = (state_q == ST_HALTED);
  assign bus.instr_done = done_q;
  assign bus.illegal_op = ill_q;

`ifdef CU_INSTR_COUNT_EN
  logic [31:0] cnt_q;

  // Retired-instruction counter; only advances on a retire event, so it holds outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else if (done_d) begin
      cnt_q <= cnt_q + 32'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign bus.instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_cu_microsequencer.sv
// Scoreboard bench for cu_microsequencer: each step queues its expected snapshot,
// the observed snapshot is queued after the edge, and each test task drains and compares.
module tb_cu_microsequencer;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HLT  = 2'd2;

  typedef struct packed {
    logic [6:0]  car;
    logic        cw_valid;
    logic        running;
    logic        halted;
    logic        done;
    logic        ill;
    logic [31:0] cnt;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_cnt = 32'd0;
  snap_t exp_q[$];
  snap_t obs_q[$];

  always #5 clk = ~clk;

  cu_seq_if bus();

  cu_microsequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic snap_t sample();
    snap_t s;
    s.car      = bus.car;
    s.cw_valid = bus.cw_valid;
    s.running  = bus.running;
    s.halted   = bus.halted;
    s.done     = bus.instr_done;
    s.ill      = bus.illegal_op;
`ifdef CU_INSTR_COUNT_EN
    s.cnt      = bus.instr_count;
`else
    s.cnt      = 32'd0;
`endif
    return s;
  endfunction

  function automatic snap_t make_exp(input logic [6:0] car, input logic [1:0] st,
                                     input logic mw, input logic done, input logic ill);
    snap_t s;
    s.car      = car;
    s.running  = (st == RUN);
    s.halted   = (st == HLT);
    s.cw_valid = (st == RUN) && !mw;
    s.done     = done;
    s.ill      = ill;
`ifdef CU_INSTR_COUNT_EN
    s.cnt      = exp_cnt;
`else
    s.cnt      = 32'd0;
`endif
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("car=%h valid=%b run=%b halt=%b done=%b ill=%b cnt=%0d",
                     s.car, s.cw_valid, s.running, s.halted, s.done, s.ill, s.cnt);
  endfunction

  task automatic step(input logic st_in, input logic [1:0] ctrl, input logic halt,
                      input logic [7:0] opc, input logic ind, input logic acc,
                      input logic mf, input logic mw,
                      input logic [6:0] ecar, input logic [1:0] est,
                      input logic edone, input logic eill);
    bus.start       = st_in;
    bus.car_ctrl    = ctrl;
    bus.cw_halt     = halt;
    bus.opcode      = opc;
    bus.ind_bit     = ind;
    bus.acc_gt_zero = acc;
    bus.mf          = mf;
    bus.mem_wait    = mw;
    if (edone) exp_cnt = exp_cnt + 32'd1;
    exp_q.push_back(make_exp(ecar, est, mw, edone, eill));
    @(posedge clk);
    #1;
    obs_q.push_back(sample());
  endtask

  task automatic inc(input logic [6:0] ecar);
    step(1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ecar, RUN, 1'b0, 1'b0);
  endtask

  task automatic go04();
    for (int i = 1; i <= 4; i++) inc(7'(i));
  endtask

  task automatic test_reset();
    snap_t e, o;
    bus.start = 1'b0; bus.car_ctrl = 2'b00; bus.cw_halt = 1'b0; bus.opcode = 8'h00;
    bus.ind_bit = 1'b0; bus.acc_gt_zero = 1'b0; bus.mf = 1'b0; bus.mem_wait = 1'b0;
    #2;
    exp_q.push_back(make_exp(7'h00, IDLE, 1'b0, 1'b0, 1'b0));
    obs_q.push_back(sample());
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, IDLE, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset got %s want %s", fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_fetch();
    snap_t e, o;
    step(1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b0, 1'b0);
    go04();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL fetch got %s want %s", fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_dispatch();
    snap_t e, o;
    step(1'b0, 2'b01, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0B, RUN, 1'b0, 1'b0);
    inc(7'h0C);
    step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b1, 1'b0);
    inc(7'h01);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL dispatch got %s want %s", fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_branch();
    snap_t e, o;
    step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b1, 1'b0);
    go04();
    step(1'b0, 2'b01, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 7'h1F, RUN, 1'b0, 1'b0);
    step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b1, 1'b0);
    go04();
    step(1'b0, 2'b01, 1'b0, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 7'h11, RUN, 1'b0, 1'b0);
    step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b1, 1'b0);
    go04();
    step(1'b0, 2'b01, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 7'h05, RUN, 1'b0, 1'b0);
    inc(7'h06);
    step(1'b0, 2'b01, 1'b0, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 7'h15, RUN, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h15, RUN, 1'b0, 1'b0);
    step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL branch got %s want %s", fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_storeh();
    snap_t e, o;
    go04();
    step(1'b0, 2'b01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 7'h07, RUN, 1'b0, 1'b0);
    inc(7'h08);
    step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h21, RUN, 1'b0, 1'b0);
    inc(7'h22); inc(7'h23); inc(7'h24);
    step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00, RUN, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL storeh got %s want %s", fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_halt();
    snap_t e, o;
    go04();
    step(1'b0, 2'b01, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 7'h13, RUN, 1'b0, 1'b0);
    inc(7'h14);
    step(1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h14, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h14, RUN, 1'b0, 1'b0);
    step(1'b0, 2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, HLT, 1'b1, 1'b0);
    step(1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, HLT, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL halt got %s want %s", fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_wrap();
    snap_t e, o;
    for (int i = 1; i <= 128; i++) inc(7'(i));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL wrap got %s want %s", fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_illegal_and_abort();
    snap_t e, o;
    go04();
    step(1'b0, 2'b01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 7'h1F, RUN, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h1F, RUN, 1'b0, 1'b0);
    step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b1, 1'b0);
    go04();
    step(1'b0, 2'b01, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 7'h1F, RUN, 1'b0, 1'b1);
    step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b1, 1'b0);
    go04();
    step(1'b0, 2'b01, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0D, RUN, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_cnt = 32'd0;
    #1;
    exp_q.push_back(make_exp(7'h00, IDLE, 1'b0, 1'b0, 1'b0));
    obs_q.push_back(sample());
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, RUN, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL illegal_abort got %s want %s", fmt(o), fmt(e)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_dispatch();
    test_branch();
    test_storeh();
    test_halt();
    test_wrap();
    test_illegal_and_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
